// File: rtl/max7219_access_arbiter.sv
// -----------------------------------------------------------------------------
// max7219_access_arbiter
//
// Shares one MAX7219 SPI frame serializer between two requesters (a static-RAM
// refresher and a scroller). After reset it first pushes the five-frame MAX7219
// init sequence. It then arbitrates round-robin between the requesters, one
// 16-bit frame per grant. A watchdog abandons any frame whose serializer never
// reports completion.
//
// Parameters
//   G_INTENSITY : intensity nibble placed in the 0x0A init frame
//   G_TIMEOUT   : cycles to wait for i_spi_done before abandoning a frame (>= 1)
//
// Ports
//   clk, rst_n                   : clock (rising edge), async active-low reset
//   i_req_static, i_data_static  : static requester frame request / frame data
//   i_req_scroll, i_data_scroll  : scroller requester frame request / frame data
//   o_ack_static, o_ack_scroll   : one-cycle frame-completed pulses
//   o_spi_start, o_spi_data      : start pulse and latched frame to serializer
//   i_spi_done                   : serializer frame-complete pulse
//   o_init_done                  : level, init sequence finished
//   o_busy                       : level, a frame is being issued or in flight
//   o_timeout_err                : one-cycle pulse, watchdog expired
// -----------------------------------------------------------------------------
module max7219_access_arbiter #(
    parameter logic [3:0] G_INTENSITY = 4'h8,
    parameter int         G_TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_static,
    input  logic [15:0] i_data_static,
    input  logic        i_req_scroll,
    input  logic [15:0] i_data_scroll,
    output logic        o_ack_static,
    output logic        o_ack_scroll,
    output logic        o_spi_start,
    output logic [15:0] o_spi_data,
    input  logic        i_spi_done,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_timeout_err
);

    localparam int WD_W = (G_TIMEOUT < 2) ? 1 : $clog2(G_TIMEOUT + 1);
    // Value the watchdog holds during the G_TIMEOUT-th wait cycle.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(G_TIMEOUT - 1);
    localparam logic [2:0] LAST_INIT_IDX = 3'd4;

    // Requester encoding used by the pointer and the winner register.
    localparam logic SEL_STATIC = 1'b0;
    localparam logic SEL_SCROLL = 1'b1;

    typedef enum logic [2:0] {
        INIT_START,
        INIT_WAIT,
        IDLE,
        START,
        BUSY
    } state_t;

    function automatic logic [15:0] init_frame(input logic [2:0] idx);
        case (idx)
            3'd0:    init_frame = 16'h0C01;              // leave shutdown
            3'd1:    init_frame = 16'h0900;              // no decode
            3'd2:    init_frame = 16'h0B07;              // scan all 8 digits
            3'd3:    init_frame = {12'h0A0, G_INTENSITY};
            default: init_frame = 16'h0F00;              // display test off
        endcase
    endfunction

    state_t          state_reg,     state_next;
    logic [2:0]      init_idx_reg,  init_idx_next;
    logic            armed_reg,     armed_next;
    logic            ptr_reg,       ptr_next;
    logic            winner_reg,    winner_next;
    logic [15:0]     data_reg,      data_next;
    logic [WD_W-1:0] wdog_reg,      wdog_next;
    logic            init_done_reg, init_done_next;
    logic [1:0]      ack_reg,       ack_next;
    logic            timeout_reg,   timeout_next;

    logic            wdog_expired;

    assign wdog_expired = (wdog_reg == WD_LAST);

    always_comb begin
        state_next     = state_reg;
        init_idx_next  = init_idx_reg;
        armed_next     = armed_reg;
        ptr_next       = ptr_reg;
        winner_next    = winner_reg;
        data_next      = data_reg;
        wdog_next      = wdog_reg;
        init_done_next = init_done_reg;
        ack_next       = 2'b00;
        timeout_next   = 1'b0;

        case (state_reg)
            INIT_START: begin
                // The first cycle after reset release only preloads frame 0,
                // so every output stays low while reset is held and the
                // start pulse always carries valid data.
                if (!armed_reg) begin
                    armed_next = 1'b1;
                    data_next  = init_frame(init_idx_reg);
                end else begin
                    wdog_next  = '0;
                    state_next = INIT_WAIT;
                end
            end

            INIT_WAIT: begin
                if (i_spi_done || wdog_expired) begin
                    // Completion wins over a watchdog expiry in the same cycle.
                    timeout_next = !i_spi_done;
                    if (init_idx_reg == LAST_INIT_IDX) begin
                        init_done_next = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        init_idx_next = init_idx_reg + 3'd1;
                        data_next     = init_frame(init_idx_reg + 3'd1);
                        state_next    = INIT_START;
                    end
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end

            IDLE: begin
                if (i_req_static || i_req_scroll) begin
                    // Under contention the requester not served last wins.
                    if (i_req_static && i_req_scroll) begin
                        winner_next = ~ptr_reg;
                    end else begin
                        winner_next = i_req_scroll ? SEL_SCROLL : SEL_STATIC;
                    end
                    data_next  = (winner_next == SEL_SCROLL) ? i_data_scroll
                                                             : i_data_static;
                    state_next = START;
                end
            end

            START: begin
                wdog_next  = '0;
                state_next = BUSY;
            end

            BUSY: begin
                if (i_spi_done) begin
                    ack_next[winner_reg] = 1'b1;
                    ptr_next             = winner_reg;
                    state_next           = IDLE;
                end else if (wdog_expired) begin
                    // Pointer untouched, so a retry goes to the same requester.
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end

            default: begin
                state_next = INIT_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= INIT_START;
            init_idx_reg  <= 3'd0;
            armed_reg     <= 1'b0;
            ptr_reg       <= SEL_SCROLL;
            winner_reg    <= SEL_STATIC;
            data_reg      <= 16'h0000;
            wdog_reg      <= '0;
            init_done_reg <= 1'b0;
            ack_reg       <= 2'b00;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            init_idx_reg  <= init_idx_next;
            armed_reg     <= armed_next;
            ptr_reg       <= ptr_next;
            winner_reg    <= winner_next;
            data_reg      <= data_next;
            wdog_reg      <= wdog_next;
            init_done_reg <= init_done_next;
            ack_reg       <= ack_next;
            timeout_reg   <= timeout_next;
        end
    end

    // armed_reg is low only while the FSM sits in its very first INIT_START
    // cycle, which keeps start/busy low during and right after reset.
    assign o_spi_start   = armed_reg && ((state_reg == INIT_START) || (state_reg == START));
    assign o_busy        = armed_reg && (state_reg != IDLE);
    assign o_spi_data    = data_reg;
    assign o_ack_static  = ack_reg[SEL_STATIC];
    assign o_ack_scroll  = ack_reg[SEL_SCROLL];
    assign o_init_done   = init_done_reg;
    assign o_timeout_err = timeout_reg;

endmodule

// File: tb/tb_max7219_access_arbiter.sv
module tb_max7219_access_arbiter;

    localparam int TMO = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_s = 1'b0;
    logic        req_c = 1'b0;
    logic [15:0] dat_s = 16'h0000;
    logic [15:0] dat_c = 16'h0000;
    logic        spur_done = 1'b0;
    logic        model_done = 1'b0;
    logic        i_spi_done;
    logic        o_ack_static, o_ack_scroll, o_spi_start, o_init_done, o_busy, o_timeout_err;
    logic [15:0] o_spi_data;

    assign i_spi_done = model_done | spur_done;

    always #5 clk = ~clk;

    max7219_access_arbiter #(
        .G_INTENSITY (4'h8),
        .G_TIMEOUT   (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_static  (req_s),
        .i_data_static (dat_s),
        .i_req_scroll  (req_c),
        .i_data_scroll (dat_c),
        .o_ack_static  (o_ack_static),
        .o_ack_scroll  (o_ack_scroll),
        .o_spi_start   (o_spi_start),
        .o_spi_data    (o_spi_data),
        .i_spi_done    (i_spi_done),
        .o_init_done   (o_init_done),
        .o_busy        (o_busy),
        .o_timeout_err (o_timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Serializer model: done is seen by the DUT in cycle start+lat.
    int lat  = 40;
    bit mute = 1'b0;
    int scnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            scnt       <= 0;
            model_done <= 1'b0;
        end else if (o_spi_start && !mute) begin
            scnt       <= lat;
            model_done <= 1'b0;
        end else if (scnt == 1) begin
            scnt       <= 0;
            model_done <= 1'b1;
        end else begin
            if (scnt > 1) scnt <= scnt - 1;
            model_done <= 1'b0;
        end
    end

    typedef struct {
        bit          rs;
        bit          rc;
        logic [15:0] ds;
        logic [15:0] dc;
        logic [15:0] exp_data;
        bit          exp_scroll;
    } vec_t;

    vec_t        vt [7];
    logic [15:0] init_tab [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string name);
        chk(name, {o_ack_static, o_ack_scroll, o_spi_start, o_spi_data,
                   o_init_done, o_busy, o_timeout_err}, 32'd0);
    endtask

    // Runs from reset release to o_init_done; requests stay as driven until then.
    task automatic run_init(input string tag);
        int  n = 0;
        int  acks = 0;
        int  errs = 0;
        bit  done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            if (o_init_done) begin
                done = 1'b1;
            end else begin
                if (o_ack_static || o_ack_scroll) acks++;
                if (o_timeout_err) errs++;
                if (o_spi_start) begin
                    if (n < 5) chk($sformatf("%s_frame%0d", tag, n), o_spi_data, init_tab[n]);
                    n++;
                end
            end
        end
        req_s = 1'b0;
        req_c = 1'b0;
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_start_count"}, n, 5);
        chk({tag, "_no_ack"}, acks, 0);
        chk({tag, "_no_err"}, errs, 0);
        $display("init %s: %0d frames, init_done=%0b", tag, n, o_init_done);
    endtask

    // Applies one table vector from IDLE and follows it to its ack.
    task automatic run_vec(input int idx);
        bit got = 1'b0;
        req_s = vt[idx].rs;
        req_c = vt[idx].rc;
        dat_s = vt[idx].ds;
        dat_c = vt[idx].dc;
        tick();
        chk($sformatf("vec%0d_start", idx), o_spi_start, 1);
        chk($sformatf("vec%0d_data", idx), o_spi_data, vt[idx].exp_data);
        dat_s = ~dat_s;
        dat_c = ~dat_c;
        for (int k = 1; k <= 30 && !got; k++) begin
            tick();
            if (o_ack_static || o_ack_scroll) begin
                got = 1'b1;
                chk($sformatf("vec%0d_ack_who", idx), {o_ack_scroll, o_ack_static},
                    vt[idx].exp_scroll ? 32'd2 : 32'd1);
                chk($sformatf("vec%0d_ack_lat", idx), k, lat + 1);
                req_s = 1'b0;
                req_c = 1'b0;
            end else begin
                chk($sformatf("vec%0d_data_hold", idx), o_spi_data, vt[idx].exp_data);
            end
        end
        chk($sformatf("vec%0d_ack_seen", idx), got, 1);
        $display("vec %0d: req=%0b%0b data=%h ack_scroll=%0b", idx, vt[idx].rs, vt[idx].rc,
                 vt[idx].exp_data, vt[idx].exp_scroll);
        req_s = 1'b0;
        req_c = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int  k;
        int  got;
        int  start_k;
        int  ack_k;
        int  err_k;
        int  acks;
        bit  bad;
        bit  last;
        bit  inflight;
        bit  exp_w;
        bit  w;
        int  nstart;
        int  nack;
        int  nerr;

        init_tab[0] = 16'h0C01;
        init_tab[1] = 16'h0900;
        init_tab[2] = 16'h0B07;
        init_tab[3] = 16'h0A08;
        init_tab[4] = 16'h0F00;

        // Pointer is "scroll last" when the table starts.
        vt[0] = '{1'b1, 1'b1, 16'h1234, 16'h5678, 16'h1234, 1'b0};
        vt[1] = '{1'b1, 1'b0, 16'h0155, 16'hFFFF, 16'h0155, 1'b0};
        vt[2] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 16'h2222, 1'b1};
        vt[3] = '{1'b1, 1'b1, 16'h3333, 16'h4444, 16'h3333, 1'b0};
        vt[4] = '{1'b0, 1'b1, 16'h5555, 16'h6666, 16'h6666, 1'b1};
        vt[5] = '{1'b0, 1'b1, 16'h7777, 16'h8888, 16'h8888, 1'b1};
        vt[6] = '{1'b1, 1'b1, 16'h9999, 16'hAAAA, 16'h9999, 1'b0};

        // Reset with requests asserted: everything low.
        req_s = 1'b1;
        req_c = 1'b1;
        dat_s = 16'hBEEF;
        dat_c = 16'hCAFE;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_zero($sformatf("reset_outputs%0d", i));
        end
        $display("reset: outputs checked low");

        // Init with requests held throughout.
        lat   = 40;
        rst_n = 1'b1;
        run_init("init");

        // Spurious done in IDLE.
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bad |= o_spi_start | o_ack_static | o_ack_scroll | o_timeout_err | o_busy;
        end
        chk("spur_done_ignored", bad, 0);
        chk("spur_data_kept", o_spi_data, 16'h0F00);
        chk("spur_init_done", o_init_done, 1);
        $display("spurious done: activity=%0b", bad);

        // Both requests held continuously: static, scroll, static, scroll.
        lat     = 4;
        req_s   = 1'b1;
        req_c   = 1'b1;
        dat_s   = 16'h1357;
        dat_c   = 16'h2468;
        got     = 0;
        ack_k   = -1;
        start_k = 0;
        for (k = 0; k < 200 && got < 4; k++) begin
            tick();
            if (o_spi_start) begin
                if (ack_k >= 0) chk("rr_restart_gap", k - ack_k, 1);
                chk($sformatf("rr_data%0d", got), o_spi_data, (got % 2) ? 32'h2468 : 32'h1357);
                start_k = k;
            end
            if (o_ack_static || o_ack_scroll) begin
                chk($sformatf("rr_ack_order%0d", got), {o_ack_scroll, o_ack_static},
                    (got % 2) ? 32'd2 : 32'd1);
                chk($sformatf("rr_ack_lat%0d", got), k - start_k, lat + 1);
                $display("rr grant %0d: scroll=%0b", got, o_ack_scroll);
                ack_k = k;
                got++;
                if (got == 4) begin
                    req_s = 1'b0;
                    req_c = 1'b0;
                end
            end
        end
        chk("rr_grants", got, 4);
        tick();
        tick();

        // Table-driven single transactions.
        lat = 3;
        for (int i = 0; i < 7; i++) run_vec(i);

        // Watchdog: scroll wins (static served last), times out, is re-granted.
        mute  = 1'b1;
        req_s = 1'b1;
        req_c = 1'b1;
        dat_s = 16'hAAAA;
        dat_c = 16'h5555;
        tick();
        chk("tmo_start", o_spi_start, 1);
        chk("tmo_data", o_spi_data, 16'h5555);
        err_k = -1;
        acks  = 0;
        for (k = 1; k <= TMO + 10 && err_k < 0; k++) begin
            tick();
            if (o_ack_static || o_ack_scroll) acks++;
            if (o_timeout_err) err_k = k;
        end
        chk("tmo_err_cycle", err_k, TMO + 1);
        chk("tmo_no_ack", acks, 0);
        chk("tmo_busy_low", o_busy, 0);
        mute = 1'b0;
        lat  = 3;
        tick();
        chk("tmo_retry_start", o_spi_start, 1);
        chk("tmo_retry_data", o_spi_data, 16'h5555);
        got = 0;
        for (k = 1; k <= 20 && got == 0; k++) begin
            tick();
            if (o_ack_static || o_ack_scroll) begin
                got = 1;
                chk("tmo_retry_ack", {o_ack_scroll, o_ack_static}, 2);
                req_s = 1'b0;
                req_c = 1'b0;
            end
        end
        chk("tmo_retry_ack_seen", got, 1);
        $display("timeout: err at cycle %0d, retry acked=%0d", err_k, got);
        tick();
        tick();

        // Done in the same cycle as the watchdog expiry: done wins.
        lat   = TMO;
        req_s = 1'b1;
        dat_s = 16'h0F0F;
        tick();
        chk("coin_start", o_spi_start, 1);
        ack_k = -1;
        err_k = -1;
        for (k = 1; k <= TMO + 10 && ack_k < 0 && err_k < 0; k++) begin
            tick();
            if (o_ack_static) begin
                ack_k = k;
                req_s = 1'b0;
            end
            if (o_timeout_err) err_k = k;
        end
        chk("coin_ack_cycle", ack_k, TMO + 1);
        chk("coin_no_err", err_k, -1);
        $display("coincident done: ack at cycle %0d", ack_k);
        req_s = 1'b0;
        tick();
        tick();

        // Done one cycle too late: error, and the late done lands in IDLE.
        lat   = TMO + 1;
        req_s = 1'b1;
        dat_s = 16'hF0F0;
        tick();
        chk("late_start", o_spi_start, 1);
        ack_k = -1;
        err_k = -1;
        for (k = 1; k <= TMO + 10 && err_k < 0; k++) begin
            tick();
            if (o_ack_static || o_ack_scroll) ack_k = k;
            if (o_timeout_err) begin
                err_k = k;
                req_s = 1'b0;
            end
        end
        chk("late_err_cycle", err_k, TMO + 1);
        chk("late_no_ack", ack_k, -1);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            bad |= o_spi_start | o_ack_static | o_ack_scroll | o_timeout_err;
        end
        chk("late_done_ignored", bad, 0);
        $display("late done: err at cycle %0d", err_k);

        // Reset during BUSY, then init is reissued from 0C01.
        mute  = 1'b1;
        req_s = 1'b1;
        dat_s = 16'h4242;
        tick();
        chk("rstbusy_start", o_spi_start, 1);
        repeat (5) tick();
        chk("rstbusy_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rstbusy_outputs");
        mute = 1'b0;
        lat  = 40;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_zero($sformatf("rstbusy_hold%0d", i));
        end
        rst_n = 1'b1;
        run_init("reinit");

        // Randomized traffic against a grant-level reference model.
        last     = 1'b1;
        inflight = 1'b0;
        exp_w    = 1'b0;
        mute     = 1'b0;
        lat      = 3;
        nstart   = 0;
        nack     = 0;
        nerr     = 0;
        for (int c = 0; c < 3000; c++) begin
            bit dropped_s;
            bit dropped_c;
            tick();
            dropped_s = 1'b0;
            dropped_c = 1'b0;
            if (o_spi_start) begin
                chk("rnd_start_when_idle", inflight, 0);
                chk("rnd_start_has_req", req_s | req_c, 1);
                w = (req_s && req_c) ? !last : req_c;
                chk("rnd_start_data", o_spi_data, w ? dat_c : dat_s);
                inflight = 1'b1;
                exp_w    = w;
                nstart++;
            end
            if (o_ack_static || o_ack_scroll) begin
                chk("rnd_ack_inflight", inflight, 1);
                chk("rnd_ack_who", {o_ack_scroll, o_ack_static}, exp_w ? 32'd2 : 32'd1);
                last     = exp_w;
                inflight = 1'b0;
                if (exp_w) begin
                    req_c     = 1'b0;
                    dropped_c = 1'b1;
                end else begin
                    req_s     = 1'b0;
                    dropped_s = 1'b1;
                end
                lat  = $urandom_range(1, 8);
                mute = ($urandom_range(0, 19) == 0);
                nack++;
            end
            if (o_timeout_err) begin
                chk("rnd_err_expected", mute, 1);
                chk("rnd_err_inflight", inflight, 1);
                inflight = 1'b0;
                lat      = $urandom_range(1, 8);
                mute     = 1'b0;
                nerr++;
            end
            chk("rnd_busy", o_busy, inflight);
            if (!req_s && !dropped_s && $urandom_range(0, 3) == 0) begin
                req_s = 1'b1;
                dat_s = 16'($urandom);
            end
            if (!req_c && !dropped_c && $urandom_range(0, 3) == 0) begin
                req_c = 1'b1;
                dat_c = 16'($urandom);
            end
        end
        $display("random: %0d starts, %0d acks, %0d timeouts", nstart, nack, nerr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
